alu_sequencer: RTL and testbench

Control sequencer for the MiniBit datapath. It accepts one ALU operation request: operand A, operand B and the ALU decoder control byte. It then issues the bus writes and active-low strobes that load A and B, execute the operation, latch the flags and read the result back. It replaces hand-driven strobe sequencing and sits between the instruction front end and the `main_reg`/`alu_decoder`/`alu`/`alu_reg` datapath on the shared 8-bit bus.

---
 rtl/alu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Drives the MiniBit bus and active-low strobes for one ALU op: load A, load B, execute, latch flags, read back.
// Each step holds its strobe low LOW_CYCLES, then holds the bus HOLD_CYCLES; done lands 5*(L+H) cycles after accept.
// No backpressure: start is only sampled in IDLE and is otherwise dropped.
module alu_sequencer #(
    parameter int LOW_CYCLES  = 1,
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic [7:0] alu_ctl,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       flag_c,
    output logic       flag_lt,
    output logic       flag_z,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in,
    input  logic       fl_carry,
    input  logic       fl_lt,
    input  logic       fl_z,
    output logic       a_r,
    output logic       b_r,
    output logic       o_r,
    output logic       flb_r,
    output logic       fl_r,
    output logic       o_w,
    output logic       a_bus,
    output logic       b_bus
);
    localparam int MAX_CYCLES = (LOW_CYCLES > HOLD_CYCLES) ? LOW_CYCLES : HOLD_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LDA, LDB, EXE, FLG, RD, DONE} state_t;

    state_t        state_q, state_d;
    logic          low_q, low_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    a_q, a_d, b_q, b_d, ctl_q, ctl_d;
    logic [7:0]    result_q, result_d;
    logic [2:0]    flags_q, flags_d;
    logic          busy_q, busy_d, done_q, done_d, bus_oe_q, bus_oe_d;
    logic [7:0]    bus_out_q, bus_out_d;
    // {a_r, b_r, o_r, flb_r, fl_r, o_w}
    logic [5:0]    strb_q, strb_d;

    function automatic state_t next_step(input state_t s);
        case (s)
            LDA:     next_step = LDB;
            LDB:     next_step = EXE;
            EXE:     next_step = FLG;
            FLG:     next_step = RD;
            default: next_step = DONE;
        endcase
    endfunction

    always_comb begin : next_state
        state_d  = state_q;
        low_d    = low_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        ctl_d    = ctl_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LDA;
                    low_d   = 1'b1;
                    cnt_d   = '0;
                    a_d     = op_a;
                    b_d     = op_b;
                    ctl_d   = alu_ctl;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (low_q) begin
                    if (cnt_q == LOW_LAST) begin
                        low_d = 1'b0;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = next_step(state_q);
                    low_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        // o_w is still low on this edge, so the bus carries the ALU output.
        if (state_q == RD && low_q && cnt_q == LOW_LAST) begin
            result_d = bus_in;
            flags_d  = {fl_carry, fl_lt, fl_z};
        end
    end

    // Outputs are decoded from the next state so they can be registered without a cycle of lag.
    always_comb begin : output_decode
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        done_d    = (state_d == DONE);
        bus_oe_d  = 1'b0;
        bus_out_d = 8'h00;
        strb_d    = 6'b111111;
        case (state_d)
            LDA: begin
                bus_oe_d  = 1'b1;
                bus_out_d = a_d;
                strb_d    = low_d ? 6'b011111 : 6'b111111;
            end
            LDB: begin
                bus_oe_d  = 1'b1;
                bus_out_d = b_d;
                strb_d    = low_d ? 6'b101111 : 6'b111111;
            end
            EXE: begin
                bus_oe_d  = 1'b1;
                bus_out_d = ctl_d;
                strb_d    = low_d ? 6'b110011 : 6'b111111;
            end
            FLG:     strb_d = low_d ? 6'b111101 : 6'b111111;
            RD:      strb_d = low_d ? 6'b111110 : 6'b111111;
            default: strb_d = 6'b111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            low_q     <= 1'b0;
            cnt_q     <= '0;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            ctl_q     <= 8'h00;
            result_q  <= 8'h00;
            flags_q   <= 3'b000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bus_oe_q  <= 1'b0;
            bus_out_q <= 8'h00;
            strb_q    <= 6'b111111;
        end else begin
            state_q   <= state_d;
            low_q     <= low_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctl_q     <= ctl_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bus_oe_q  <= bus_oe_d;
            bus_out_q <= bus_out_d;
            strb_q    <= strb_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign {flag_c, flag_lt, flag_z} = flags_q;
    assign bus_oe  = bus_oe_q;
    assign bus_out = bus_out_q;
    assign {a_r, b_r, o_r, flb_r, fl_r, o_w} = strb_q;
    assign a_bus   = 1'b1;
    assign b_bus   = 1'b1;
endmodule

// File: tb/tb_alu_sequencer.sv
// Runs two sequencers (L=1/H=1 and L=2/H=3) against a timing/arithmetic reference and a modelled datapath.
module tb_alu_sequencer;
    logic clk;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [10:0] val;
    } exp_t;

    localparam logic [7:0] ADD = 8'b00100000;
    localparam logic [7:0] SUB = 8'b00010000;
    localparam logic [7:0] AND = 8'b00001000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns {carry, lt, zero, result[7:0]} for the datapath ops the bench uses.
    function automatic logic [10:0] alu_fn(input logic [7:0] ctl, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        if (ctl == ADD)      s = {1'b0, a} + {1'b0, b};
        else if (ctl == SUB) s = {1'b0, a} - {1'b0, b};
        else                 s = {1'b0, a & b};
        return {s[8], (a < b), (s[7:0] == 8'h00), s[7:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int L   = (k == 0) ? 1 : 2;
        localparam int H   = (k == 0) ? 1 : 3;
        localparam int P   = L + H;
        localparam int SEQ = 5 * P;

        logic       rst_n, start;
        logic [7:0] op_a, op_b, alu_ctl, bus_in, result, bus_out;
        logic       busy, done, flag_c, flag_lt, flag_z, bus_oe;
        logic       fl_carry, fl_lt, fl_z;
        logic       a_r, b_r, o_r, flb_r, fl_r, o_w, a_bus, b_bus;
        bit         fin = 1'b0;

        alu_sequencer #(.LOW_CYCLES(L), .HOLD_CYCLES(H)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .alu_ctl(alu_ctl),
            .busy(busy), .done(done), .result(result), .flag_c(flag_c), .flag_lt(flag_lt), .flag_z(flag_z),
            .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
            .fl_carry(fl_carry), .fl_lt(fl_lt), .fl_z(fl_z),
            .a_r(a_r), .b_r(b_r), .o_r(o_r), .flb_r(flb_r), .fl_r(fl_r), .o_w(o_w),
            .a_bus(a_bus), .b_bus(b_bus)
        );

        // Datapath registers: load while strobe low, drive bus only while o_w low.
        logic [7:0]  dp_a, dp_b, dp_o;
        logic [2:0]  dp_f;
        logic [10:0] dp_r;
        assign bus_in = o_w ? (dp_o ^ 8'hA5) : dp_o;
        assign {fl_carry, fl_lt, fl_z} = dp_f;

        always @(negedge clk) begin
            if (!a_r) dp_a = bus_out;
            if (!b_r) dp_b = bus_out;
            dp_r = alu_fn(bus_out, dp_a, dp_b);
            if (!o_r)   dp_o = dp_r[7:0];
            if (!flb_r) dp_f = dp_r[10:8];
        end

        // Reference: j = cycles since accept (-1 when idle), operands latched at accept.
        int          j = -1;
        int          cyc = 0;
        bit          armed = 1'b0;
        logic [7:0]  m_a, m_b, m_c;
        logic [10:0] m_res;
        exp_t        sb[$];
        exp_t        e_push, e_pop;

        always @(posedge clk) begin
            cyc++;
            if (!rst_n) begin
                j     = -1;
                armed = 1'b1;
                m_res = 11'd0;
                sb.delete();
            end else if (j < 0) begin
                if (start) begin
                    j   = 0;
                    m_a = op_a;
                    m_b = op_b;
                    m_c = alu_ctl;
                    e_push.cyc = 32'(cyc + SEQ);
                    e_push.val = alu_fn(m_c, m_a, m_b);
                    sb.push_back(e_push);
                end
            end else begin
                j++;
                if (j > SEQ) j = -1;
                else if (j == 4 * P + L) m_res = alu_fn(m_c, m_a, m_b);
            end
        end

        logic [5:0] e_strb;
        logic [7:0] e_out;
        logic       e_oe, e_busy, e_done;
        int         step;

        always @(negedge clk) begin
            if (armed) begin
                e_strb = 6'b111111; e_out = 8'h00; e_oe = 1'b0; e_busy = 1'b0; e_done = 1'b0;
                if (j >= 0 && j < SEQ) begin
                    step   = j / P;
                    e_busy = 1'b1;
                    if ((j % P) < L) begin
                        case (step)
                            0:       e_strb = 6'b011111;
                            1:       e_strb = 6'b101111;
                            2:       e_strb = 6'b110011;
                            3:       e_strb = 6'b111101;
                            default: e_strb = 6'b111110;
                        endcase
                    end
                    if (step < 3) begin
                        e_oe  = 1'b1;
                        e_out = (step == 0) ? m_a : (step == 1) ? m_b : m_c;
                    end
                end else if (j == SEQ) begin
                    e_done = 1'b1;
                end
                check($sformatf("inst%0d outputs cyc %0d {busy,done,strb,abus,bbus,oe,out,flags,res}", k, cyc),
                      {busy, done, a_r, b_r, o_r, flb_r, fl_r, o_w, a_bus, b_bus, bus_oe, bus_out,
                       flag_c, flag_lt, flag_z, result},
                      {e_busy, e_done, e_strb, 2'b11, e_oe, e_out, m_res});
                if (done === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL inst%0d unexpected done at cyc %0d: got done=1, expected none", k, cyc);
                    end else begin
                        e_pop = sb.pop_front();
                        check($sformatf("inst%0d done_cycle", k), 64'(cyc), 64'(e_pop.cyc));
                        check($sformatf("inst%0d result_flags", k),
                              {flag_c, flag_lt, flag_z, result}, e_pop.val);
                    end
                end
            end
        end

        task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
            op_a = a; op_b = b; alu_ctl = c; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic wait_idle();
            for (int c = 0; c < 400 && j >= 0; c++) @(negedge clk);
        endtask

        logic [7:0] ctl_tab [3];

        initial begin
            ctl_tab[0] = ADD; ctl_tab[1] = SUB; ctl_tab[2] = AND;
            rst_n = 1'b0; start = 1'b0; op_a = 8'h00; op_b = 8'h00; alu_ctl = 8'h00;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);

            issue(8'd5, 8'd7, ADD);     wait_idle();
            issue(8'd200, 8'd100, ADD); wait_idle();
            issue(8'd0, 8'd0, ADD);     wait_idle();
            issue(8'd255, 8'd1, ADD);   wait_idle();
            for (int i = 0; i < 10; i++) begin
                issue(8'($urandom), 8'($urandom), ctl_tab[$urandom_range(0, 2)]);
                wait_idle();
            end

            // start with other operands while in LDB must be dropped
            issue(8'h11, 8'h22, ADD);
            for (int c = 0; c < 100 && j < P; c++) @(negedge clk);
            op_a = 8'h99; op_b = 8'h77; alu_ctl = SUB; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_idle();

            // operand changes right after accept must not leak onto the bus
            issue(8'h3C, 8'h5A, SUB);
            op_a = 8'hC3; op_b = 8'hA5; alu_ctl = AND;
            wait_idle();

            // reset during EXE LOW, then a clean run from LDA
            issue(8'd40, 8'd2, ADD);
            for (int c = 0; c < 100 && j < 2 * P; c++) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            issue(8'd9, 8'd9, SUB);
            wait_idle();

            // start held high: operations accepted at the maximum back-to-back rate
            start = 1'b1;
            for (int c = 0; c < 2 * (SEQ + 2) + 3; c++) begin
                op_a = 8'($urandom); op_b = 8'($urandom); alu_ctl = ctl_tab[$urandom_range(0, 2)];
                @(negedge clk);
            end
            start = 1'b0;
            wait_idle();
            repeat (5) @(negedge clk);
            check($sformatf("inst%0d scoreboard_empty", k), 64'(sb.size()), 64'd0);
            fin = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 20000 && !(g_inst[0].fin && g_inst[1].fin); c++) @(posedge clk);
        if (!(g_inst[0].fin && g_inst[1].fin)) begin
            checks++;
            errors++;
            $display("FAIL timeout: got unfinished stimulus, expected completion within 20000 cycles");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
